cla_multiword_seq: RTL and testbench
====================================

# cla_multiword_seq

Sequencer that reuses one instance of the team's 16-bit carry-lookahead adder (`carry_look_ahead_16bit`) over several cycles to add operands of 16*WORDS bits. The carry is held in a register and chained from one 16-bit slice to the next. Sits between a requester with a valid/ready operand interface and a consumer with a valid/ready result interface. It trades latency for area against a full-width adder.

## Interface
Parameters:
- WORDS, default 4: number of 16-bit slices. Operand width is W = 16*WORDS. Legal range is 2..16.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start_valid  in  1  operand request
- start_ready  out  1  block can accept a request; high only in IDLE
- a  in  W  operand A; sampled only on accept
- b  in  W  operand B; sampled only on accept
- cin  in  1  carry into bit 0; sampled only on accept
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- sum  out  W  registered sum
- cout  out  1  carry out of bit W-1
- ovf  out  1  signed overflow of the W-bit add
- busy  out  1  high in RUN or DONE

## Operation
- Reset values: state=IDLE, idx=0, carry_r=0, a_r=0, b_r=0, sum=0, cout=0, ovf=0, res_valid=0, busy=0, start_ready=1 once rst_n is high.
- Accept: start_valid & start_ready at a rising edge.
- FSM states: IDLE, RUN, DONE.
- IDLE
  - On accept: a_r<=a, b_r<=b, carry_r<=cin, idx<=0, sum<=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN
  - Adder inputs: a_r[16*idx+:16], b_r[16*idx+:16], carry_r.
  - Each edge: sum[16*idx+:16]<=adder sum, carry_r<=adder cout.
  - If idx==WORDS-1: cout<=adder cout, ovf<=(a_r[W-1]==b_r[W-1]) & (adder sum[15]!=a_r[W-1]), go to DONE.
  - Else idx<=idx+1.
- DONE
  - res_valid=1. sum, cout and ovf are held stable.
  - On res_valid & res_ready: go to IDLE and deassert res_valid. sum, cout and ovf keep their values until the next accept.
- start_valid is ignored outside IDLE; start_ready=0 there, so no request is queued or lost silently.
- Arithmetic is modulo 2^W plus cout; there is no saturation.
- idx width is clog2(WORDS). idx never wraps past WORDS-1.

## Timing
- Accept edge = E0. RUN occupies edges E1..E_WORDS. res_valid rises after E_WORDS, giving a latency of WORDS cycles.
- Minimum request period is WORDS+2 cycles:
  - the DONE handshake edge returns the FSM to IDLE;
  - the next accept happens on the following edge.
- Result backpressure is unbounded. The FSM stays in DONE with res_valid=1 until res_ready is high.
- Reset asserted mid-RUN or mid-DONE:
  - immediate return to IDLE with all registers at reset values;
  - the in-flight operation is discarded and res_valid never asserts for it.
- No combinational path from start_valid to start_ready. No combinational path from res_ready to res_valid.

## Test plan
All scenarios use WORDS=4.
- Reset: hold rst_n low for 3 cycles, then release.
  - Required: all outputs 0 and start_ready=1 on the first cycle after release.
- Full carry ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0.
  - Required: sum=0, cout=1, ovf=0.
  - Required: res_valid high exactly 4 edges after the accept edge.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=0x1, cin=0.
  - Required: sum=0x8000_0000_0000_0000, cout=0, ovf=1.
  - Then a=0x1234_5678_9ABC_DEF0, b=0x1111_1111_1111_1111, cin=1.
  - Required: sum=0x2345_6789_ABCD_F002, cout=0, ovf=0.
- Backpressure: hold res_ready=0 for 10 cycles while start_valid=1 with new operands.
  - Required: sum, cout, ovf and res_valid stable; start_ready=0; the second request is accepted only after the result handshake.
- Reset mid-RUN: assert rst_n low after 2 RUN edges, then issue a=5, b=7.
  - Required: no res_valid for the aborted operation.
  - Required: the next result is sum=12, cout=0.
- Streaming: start_valid=1 and res_ready=1 continuously with 20 random operand pairs.
  - Required: each result matches a 65-bit reference sum.
  - Required: results appear exactly every 6 cycles.

Source files
------------

// File: rtl/cla_multiword_seq.sv
// cla_multiword_seq: multi-cycle W-bit adder (W = 16*WORDS) built from a single
// 16-bit carry-lookahead adder. One 16-bit slice is added per RUN cycle, and a
// carry register links each slice to the next.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start_valid/start_ready  operand handshake (a, b, cin are sampled on accept)
//   res_valid/res_ready      result handshake (sum, cout, ovf are held in DONE)
//   sum, cout, ovf           registered W-bit sum, carry out, signed overflow
//   busy                     high while an operation is in RUN or DONE

// carry_look_ahead_16bit: 16-bit adder made of four 4-bit lookahead groups
// and a second-level lookahead unit across the groups.
// Ports: i_a, i_b operands; i_cin carry in; o_sum sum; o_cout carry out.
module carry_look_ahead_16bit (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);
  logic [15:0] w_g, w_p, w_c;
  logic [3:0]  w_gg, w_gp;
  logic [4:0]  w_bc;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  for (genvar k = 0; k < 4; k++) begin : g_grp
    assign w_gg[k] = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
                   | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                   | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
    assign w_gp[k] = &w_p[4*k+:4];
    assign w_c[4*k]   = w_bc[k];
    assign w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_bc[k]);
    assign w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                      | (w_p[4*k+1] & w_p[4*k] & w_bc[k]);
    assign w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                      | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                      | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_bc[k]);
  end

  // Group carries are fully expanded so no carry ripples between groups.
  assign w_bc[0] = i_cin;
  assign w_bc[1] = w_gg[0] | (w_gp[0] & i_cin);
  assign w_bc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & i_cin);
  assign w_bc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[2] & w_gp[1] & w_gp[0] & i_cin);
  assign w_bc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & i_cin);

  assign o_sum  = w_p ^ w_c;
  assign o_cout = w_bc[4];
endmodule

module cla_multiword_seq #(
  parameter int unsigned WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [16*WORDS-1:0] a,
  input  logic [16*WORDS-1:0] b,
  input  logic                cin,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [16*WORDS-1:0] sum,
  output logic                cout,
  output logic                ovf,
  output logic                busy
);
  localparam int unsigned W  = 16 * WORDS;
  localparam int unsigned IW = $clog2(WORDS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [IW-1:0]   r_idx;
  logic            r_carry;
  logic [W-1:0]    r_a, r_b, r_sum;
  logic            r_cout, r_ovf;
  logic [15:0]     w_slice_a, w_slice_b, w_slice_sum;
  logic            w_slice_cout, w_last, w_accept;

  assign w_slice_a = r_a[r_idx*16 +: 16];
  assign w_slice_b = r_b[r_idx*16 +: 16];
  assign w_last    = (r_idx == IW'(WORDS - 1));
  assign w_accept  = start_valid & start_ready;

  carry_look_ahead_16bit u_cla (
    .i_a    (w_slice_a),
    .i_b    (w_slice_b),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Handshake outputs decode only the state register, so neither ready nor
  // valid has a combinational path from the opposite handshake input.
  always_comb begin
    w_next      = r_state;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) w_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_sum   <= '0;
          end
        end
        S_RUN: begin
          r_sum[r_idx*16 +: 16] <= w_slice_sum;
          r_carry               <= w_slice_cout;
          if (w_last) begin
            r_cout <= w_slice_cout;
            r_ovf  <= (r_a[W-1] == r_b[W-1]) & (w_slice_sum[15] != r_a[W-1]);
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;
endmodule

// File: tb/tb_cla_multiword_seq.sv
module tb_cla_multiword_seq;
  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 16 * WORDS;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk, rst_n, start_valid, start_ready, cin;
  logic         res_valid, res_ready, cout, ovf, busy;
  logic [W-1:0] a, b, sum;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  cla_multiword_seq #(.WORDS(WORDS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
    .ovf         (ovf),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: unsigned (W+1)-bit sum for sum/cout, sign-extended sum for ovf.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c);
    logic [W:0] u, s;
    exp_t e;
    u   = {1'b0, x} + {1'b0, y} + (W+1)'(c);
    s   = {x[W-1], x} + {y[W-1], y} + (W+1)'(c);
    e.s = u[W-1:0];
    e.c = u[W];
    e.o = s[W] ^ s[W-1];
    return e;
  endfunction

  task automatic drive_req(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    @(negedge clk);
    a = x; b = y; cin = c; start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (!res_valid && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  task automatic take_result;
    @(negedge clk) res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1; start_valid = 1'b0; res_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    checks++; if (sum !== '0) begin errors++; $display("FAIL reset_sum: got %h expected 0", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", cout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready: got %b expected 1", start_ready); end
  endtask

  task automatic test_ripple;
    int   n;
    exp_t e;
    sb.push_back(model(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0));
    drive_req(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    checks++; if (busy !== 1'b1 || start_ready !== 1'b0) begin errors++;
      $display("FAIL ripple_accept: got busy=%b start_ready=%b expected 1/0", busy, start_ready); end
    wait_result(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL ripple_latency: got %0d edges expected 4", n); end
    e = sb.pop_front();
    checks++; if ({cout, sum, ovf} !== {e.c, e.s, e.o}) begin errors++;
      $display("FAIL ripple_model: got %b/%h/%b expected %b/%h/%b", cout, sum, ovf, e.c, e.s, e.o); end
    checks++; if ({cout, sum, ovf} !== {1'b1, 64'h0, 1'b0}) begin errors++;
      $display("FAIL ripple_const: got %b/%h/%b expected 1/0/0", cout, sum, ovf); end
    take_result;
    checks++; if (res_valid !== 1'b0 || start_ready !== 1'b1 || sum !== '0 || cout !== 1'b1) begin errors++;
      $display("FAIL ripple_after_handshake: got rv=%b sr=%b sum=%h cout=%b expected 0/1/0/1", res_valid, start_ready, sum, cout); end
  endtask

  task automatic test_overflow;
    logic [W-1:0] xs[2], ys[2], es[2];
    logic         cs[2], ec[2], eo[2];
    int           n;
    exp_t         e;
    xs[0] = 64'h7FFF_FFFF_FFFF_FFFF; ys[0] = 64'h1; cs[0] = 1'b0;
    es[0] = 64'h8000_0000_0000_0000; ec[0] = 1'b0; eo[0] = 1'b1;
    xs[1] = 64'h1234_5678_9ABC_DEF0; ys[1] = 64'h1111_1111_1111_1111; cs[1] = 1'b1;
    es[1] = 64'h2345_6789_ABCD_F002; ec[1] = 1'b0; eo[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(model(xs[i], ys[i], cs[i]));
      drive_req(xs[i], ys[i], cs[i]);
      wait_result(n);
      checks++; if (n !== 4) begin errors++; $display("FAIL ovf_latency[%0d]: got %0d expected 4", i, n); end
      e = sb.pop_front();
      checks++; if ({cout, sum, ovf} !== {e.c, e.s, e.o}) begin errors++;
        $display("FAIL ovf_model[%0d]: got %b/%h/%b expected %b/%h/%b", i, cout, sum, ovf, e.c, e.s, e.o); end
      checks++; if ({cout, sum, ovf} !== {ec[i], es[i], eo[i]}) begin errors++;
        $display("FAIL ovf_const[%0d]: got %b/%h/%b expected %b/%h/%b", i, cout, sum, ovf, ec[i], es[i], eo[i]); end
      take_result;
    end
  endtask

  task automatic test_backpressure;
    int   n, bad;
    exp_t e;
    sb.push_back(model(64'h8000_0000_0000_0001, 64'h8000_0000_0000_0002, 1'b1));
    drive_req(64'h8000_0000_0000_0001, 64'h8000_0000_0000_0002, 1'b1);
    wait_result(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL bp_latency: got %0d expected 4", n); end
    @(negedge clk);
    a = 64'h0000_0000_0000_00AA; b = 64'h0000_0000_0000_0055; cin = 1'b0; start_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || start_ready !== 1'b0 || sum !== sb[0].s ||
          cout !== sb[0].c || ovf !== sb[0].o) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad); end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    e = sb.pop_front();
    checks++; if (res_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL bp_handshake: got rv=%b sr=%b busy=%b expected 0/1/0", res_valid, start_ready, busy); end
    checks++; if ({cout, sum, ovf} !== {e.c, e.s, e.o}) begin errors++;
      $display("FAIL bp_first_result: got %b/%h/%b expected %b/%h/%b", cout, sum, ovf, e.c, e.s, e.o); end
    sb.push_back(model(64'h0000_0000_0000_00AA, 64'h0000_0000_0000_0055, 1'b0));
    @(posedge clk);
    #1 start_valid = 1'b0;
    checks++; if (busy !== 1'b1 || start_ready !== 1'b0) begin errors++;
      $display("FAIL bp_second_accept: got busy=%b sr=%b expected 1/0", busy, start_ready); end
    wait_result(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL bp_second_latency: got %0d expected 4", n); end
    e = sb.pop_front();
    checks++; if ({cout, sum, ovf} !== {e.c, e.s, e.o}) begin errors++;
      $display("FAIL bp_second_result: got %b/%h/%b expected %b/%h/%b", cout, sum, ovf, e.c, e.s, e.o); end
    take_result;
  endtask

  task automatic test_reset_mid_run;
    int   n, seen;
    exp_t e;
    drive_req(64'hDEAD_BEEF_0000_FFFF, 64'h0123_4567_89AB_CDEF, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || start_ready !== 1'b1 || res_valid !== 1'b0 || sum !== '0) begin errors++;
      $display("FAIL midrun_reset_state: got busy=%b sr=%b rv=%b sum=%h expected 0/1/0/0", busy, start_ready, res_valid, sum); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrun_no_result: got %0d valid cycles expected 0", seen); end
    sb.push_back(model(64'd5, 64'd7, 1'b0));
    drive_req(64'd5, 64'd7, 1'b0);
    wait_result(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL midrun_latency: got %0d expected 4", n); end
    e = sb.pop_front();
    checks++; if ({cout, sum} !== {e.c, e.s} || {cout, sum} !== {1'b0, 64'd12}) begin errors++;
      $display("FAIL midrun_result: got %b/%h expected 0/%h", cout, sum, 64'd12); end
    take_result;
  endtask

  task automatic test_streaming;
    logic [W-1:0] xs[20], ys[20];
    logic         cs[20];
    int           sent, recv, last, bad_val, bad_gap;
    exp_t         e;
    for (int i = 0; i < 20; i++) begin
      xs[i] = {$urandom, $urandom};
      ys[i] = {$urandom, $urandom};
      cs[i] = 1'($urandom_range(0, 1));
    end
    xs[3] = 64'hFFFF_FFFF_FFFF_FFFF; ys[3] = 64'hFFFF_FFFF_FFFF_FFFF; cs[3] = 1'b1;
    sent = 0; recv = 0; last = -1; bad_val = 0; bad_gap = 0;
    res_ready = 1'b1;
    for (int cyc = 0; cyc < 400 && recv < 20; cyc++) begin
      @(negedge clk);
      if (res_valid) begin
        if (sb.size() == 0) bad_val++;
        else begin
          e = sb.pop_front();
          if ({cout, sum} !== {e.c, e.s} || ovf !== e.o) begin
            bad_val++;
            $display("FAIL stream_result[%0d]: got %b/%h/%b expected %b/%h/%b", recv, cout, sum, ovf, e.c, e.s, e.o);
          end
        end
        if (last >= 0 && cyc - last != 6) bad_gap++;
        last = cyc;
        recv++;
      end
      if (start_ready && sent < 20) begin
        a = xs[sent]; b = ys[sent]; cin = cs[sent]; start_valid = 1'b1;
        sb.push_back(model(xs[sent], ys[sent], cs[sent]));
        sent++;
      end else if (sent == 20) begin
        start_valid = 1'b0;
      end
    end
    start_valid = 1'b0;
    res_ready   = 1'b0;
    checks++; if (bad_val !== 0) begin errors++; $display("FAIL stream_values: got %0d bad results expected 0", bad_val); end
    checks++; if (bad_gap !== 0) begin errors++; $display("FAIL stream_period: got %0d bad gaps expected 0", bad_gap); end
    checks++; if (recv !== 20) begin errors++; $display("FAIL stream_count: got %0d results expected 20", recv); end
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL stream_scoreboard: got %0d left expected 0", sb.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_ripple;
    test_overflow;
    test_backpressure;
    test_reset_mid_run;
    test_streaming;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
